// File: rtl/console_pkg.sv
// Shared definitions for the text console writer: control codes, FSM states
// and small helpers used by both the top level and the cursor block.
package console_pkg;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CLR_LINE   = 2'd1,
    CLR_SCREEN = 2'd2
  } state_t;

  // Row + 1 wrapped at the screen height; compare only, no modulo operator.
  function automatic int unsigned row_inc(input int unsigned r, input int unsigned rows);
    return (r + 1 >= rows) ? 0 : r + 1;
  endfunction

  // Bytes that land in a cell verbatim.
  function automatic logic is_print(input logic [7:0] b);
    return (b >= CH_SPACE) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/text_console_cursor.sv
// Cursor column/row and circular row base. Resolves the physical row of the
// cursor and the physical row that a NEWLINE will need cleared.
module text_console_cursor
  import console_pkg::*;
#(
  parameter int COLS        = 80,
  parameter int ROWS        = 30,
  parameter int COL_W       = $clog2(COLS),
  parameter int ROW_W       = $clog2(ROWS),
  parameter int SCROLL_MODE = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_accept,
  input  logic [7:0]       i_data,
  input  logic             i_home,
  output logic [COL_W-1:0] o_col,
  output logic [ROW_W-1:0] o_row,
  output logic [ROW_W-1:0] o_base,
  output logic [ROW_W-1:0] o_phys,
  output logic [ROW_W-1:0] o_nl_row,
  output logic             o_newline,
  output logic             o_wrap
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [ROW_W:0]   ROWS_X   = (ROW_W+1)'(ROWS);

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row, r_base;
  logic [ROW_W:0]   w_sum;
  logic [ROW_W-1:0] w_phys;
  logic             w_print, w_nl, w_last_row;

  // Physical row via add + conditional subtract, plus NEWLINE decode.
  always_comb begin
    w_sum      = {1'b0, r_row} + {1'b0, r_base};
    w_phys     = (w_sum >= ROWS_X) ? ROW_W'(w_sum - ROWS_X) : w_sum[ROW_W-1:0];
    w_print    = is_print(i_data);
    w_nl       = (w_print && (r_col == COL_LAST)) || (i_data == CH_LF);
    w_last_row = (r_row == ROW_LAST);
    o_wrap     = w_nl && w_last_row && (SCROLL_MODE == 0);
    // At the bottom line the row being exposed is the old base (scroll) or
    // row 0 (wrap, where the base never moves off 0).
    o_nl_row   = w_last_row ? r_base : ROW_W'(row_inc(32'(w_phys), ROWS));
  end

  // Cursor/base update on each accepted byte; home after a full-screen clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_col  <= '0;
      r_row  <= '0;
      r_base <= '0;
    end else if (i_home) begin
      r_col  <= '0;
      r_row  <= '0;
      r_base <= '0;
    end else if (i_accept) begin
      if (w_nl) begin
        r_col <= '0;
        if (!w_last_row)          r_row  <= r_row + 1'b1;
        else if (SCROLL_MODE != 0) r_base <= ROW_W'(row_inc(32'(r_base), ROWS));
        else                      r_row  <= '0;
      end else if (w_print) begin
        r_col <= r_col + 1'b1;
      end else if (i_data == CH_CR) begin
        r_col <= '0;
      end else if ((i_data == CH_BS) && (r_col != '0)) begin
        r_col <= r_col - 1'b1;
      end
    end
  end

  assign o_col     = r_col;
  assign o_row     = r_row;
  assign o_base    = r_base;
  assign o_phys    = w_phys;
  assign o_newline = w_nl;

endmodule

// File: rtl/text_console_writer.sv
// Character-stream writer for the text buffer: handshake, control-code FSM,
// line/screen clear sequencing and the registered single-port write.
module text_console_writer
  import console_pkg::*;
#(
  parameter int         COLS        = 80,
  parameter int         ROWS        = 30,
  parameter int         COL_W       = $clog2(COLS),
  parameter int         ROW_W       = $clog2(ROWS),
  parameter int         SCROLL_MODE = 1,
  parameter logic [7:0] FILL_CHAR   = 8'h20
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_clear,
  input  logic                   i_valid,
  input  logic [7:0]             i_data,
  output logic                   o_ready,
  output logic [ROW_W+COL_W-1:0] o_address,
  output logic [7:0]             o_data,
  output logic                   o_we,
  output logic [COL_W-1:0]       o_cursor_col,
  output logic [ROW_W-1:0]       o_cursor_row,
  output logic [ROW_W-1:0]       o_row_base,
  output logic                   o_full,
  output logic                   o_busy
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  state_t                 r_state, w_next;
  logic [COL_W-1:0]       r_cnt_col;
  logic [ROW_W-1:0]       r_cnt_row, r_clr_row;
  logic                   r_we, r_full;
  logic [ROW_W+COL_W-1:0] r_addr;
  logic [7:0]             r_data;

  logic                   w_accept, w_line_done, w_scr_done, w_home;
  logic                   w_we, w_full;
  logic [ROW_W+COL_W-1:0] w_addr;
  logic [7:0]             w_data;
  logic [COL_W-1:0]       w_col, w_col_m1;
  logic [ROW_W-1:0]       w_row, w_base, w_phys, w_nl_row;
  logic                   w_newline, w_wrap;

  assign o_ready     = (r_state == IDLE) && !i_clear;
  assign w_accept    = o_ready && i_valid;
  assign w_line_done = (r_cnt_col == COL_LAST);
  assign w_scr_done  = w_line_done && (r_cnt_row == ROW_LAST);
  assign w_home      = (r_state == CLR_SCREEN) && w_scr_done && !i_clear;
  assign w_col_m1    = w_col - 1'b1;

  text_console_cursor #(
    .COLS(COLS), .ROWS(ROWS), .COL_W(COL_W), .ROW_W(ROW_W), .SCROLL_MODE(SCROLL_MODE)
  ) u_cursor (
    .i_clk(i_clk), .i_rst(i_rst), .i_accept(w_accept), .i_data(i_data), .i_home(w_home),
    .o_col(w_col), .o_row(w_row), .o_base(w_base), .o_phys(w_phys),
    .o_nl_row(w_nl_row), .o_newline(w_newline), .o_wrap(w_wrap)
  );

  // State register; reset lands in a full-screen clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= CLR_SCREEN;
    else       r_state <= w_next;
  end

  // Next state; i_clear overrides everything and restarts the screen clear.
  always_comb begin
    w_next = r_state;
    if (i_clear) begin
      w_next = CLR_SCREEN;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          if (i_data == CH_FF) w_next = CLR_SCREEN;
          else if (w_newline)  w_next = CLR_LINE;
        end
        CLR_LINE:   if (w_line_done) w_next = IDLE;
        CLR_SCREEN: if (w_scr_done)  w_next = IDLE;
        default:    w_next = IDLE;
      endcase
    end
  end

  // Write-port and o_full values for the next cycle.
  always_comb begin
    w_we   = 1'b0;
    w_addr = '0;
    w_data = '0;
    w_full = 1'b0;
    if (!i_clear) begin
      case (r_state)
        IDLE: if (w_accept) begin
          w_full = w_wrap;
          if (is_print(i_data)) begin
            w_we   = 1'b1;
            w_addr = {w_phys, w_col};
            w_data = i_data;
          end else if ((i_data == CH_BS) && (w_col != '0)) begin
            w_we   = 1'b1;
            w_addr = {w_phys, w_col_m1};
            w_data = FILL_CHAR;
          end
        end
        CLR_LINE: begin
          w_we   = 1'b1;
          w_addr = {r_clr_row, r_cnt_col};
          w_data = FILL_CHAR;
        end
        CLR_SCREEN: begin
          w_we   = 1'b1;
          w_addr = {r_cnt_row, r_cnt_col};
          w_data = FILL_CHAR;
        end
        default: ;
      endcase
    end
  end

  // Registered write port so every write lands one cycle after its cause.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_full <= 1'b0;
    end else begin
      r_we   <= w_we;
      r_addr <= w_addr;
      r_data <= w_data;
      r_full <= w_full;
    end
  end

  // Clear counters (separate row/col) and the latched row for line clears.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt_col <= '0;
      r_cnt_row <= '0;
      r_clr_row <= '0;
    end else begin
      if (w_accept && w_newline) r_clr_row <= w_nl_row;
      if (i_clear || (r_state == IDLE)) begin
        r_cnt_col <= '0;
        r_cnt_row <= '0;
      end else if (r_state == CLR_LINE) begin
        r_cnt_col <= w_line_done ? '0 : r_cnt_col + 1'b1;
      end else if (w_line_done) begin
        r_cnt_col <= '0;
        r_cnt_row <= w_scr_done ? '0 : r_cnt_row + 1'b1;
      end else begin
        r_cnt_col <= r_cnt_col + 1'b1;
      end
    end
  end

  assign o_we         = r_we;
  assign o_address    = r_addr;
  assign o_data       = r_data;
  assign o_full       = r_full;
  assign o_busy       = (r_state != IDLE);
  assign o_cursor_col = w_col;
  assign o_cursor_row = w_row;
  assign o_row_base   = w_base;

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench: two writers (scroll and wrap mode, COLS=8 ROWS=4) share one
// stimulus stream; expected writes and cursor values are hand-computed.
module tb_text_console_writer;

  logic       clk = 1'b0;
  logic       rst, clr, valid;
  logic [7:0] data;

  logic       a_ready, a_we, a_full, a_busy;
  logic [4:0] a_addr;
  logic [7:0] a_data;
  logic [2:0] a_col;
  logic [1:0] a_row, a_base;

  logic       b_ready, b_we, b_full, b_busy;
  logic [4:0] b_addr;
  logic [7:0] b_data;
  logic [2:0] b_col;
  logic [1:0] b_row, b_base;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  text_console_writer #(.COLS(8), .ROWS(4), .SCROLL_MODE(1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_clear(clr), .i_valid(valid), .i_data(data),
    .o_ready(a_ready), .o_address(a_addr), .o_data(a_data), .o_we(a_we),
    .o_cursor_col(a_col), .o_cursor_row(a_row), .o_row_base(a_base),
    .o_full(a_full), .o_busy(a_busy)
  );

  text_console_writer #(.COLS(8), .ROWS(4), .SCROLL_MODE(0)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_clear(clr), .i_valid(valid), .i_data(data),
    .o_ready(b_ready), .o_address(b_addr), .o_data(b_data), .o_we(b_we),
    .o_cursor_col(b_col), .o_cursor_row(b_row), .o_row_base(b_base),
    .o_full(b_full), .o_busy(b_busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expect a write on instance A (and optionally the same on B).
  task automatic chk_wr(input string tag, input logic [4:0] addr, input logic [7:0] d, input bit both);
    chk({tag, "_we"}, 32'(a_we), 32'd1);
    chk({tag, "_addr"}, 32'(a_addr), 32'(addr));
    chk({tag, "_data"}, 32'(a_data), 32'(d));
    if (both) begin
      chk({tag, "_b_we"}, 32'(b_we), 32'd1);
      chk({tag, "_b_addr"}, 32'(b_addr), 32'(addr));
    end
  endtask

  // Present one byte for exactly one edge.
  task automatic send(input logic [7:0] b);
    valid = 1'b1;
    data  = b;
    tick();
    valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; valid = 1'b0; data = 8'h00;
    tick(); tick();
    chk("rst_we", 32'(a_we), 0);
    chk("rst_addr", 32'(a_addr), 0);
    chk("rst_data", 32'(a_data), 0);
    chk("rst_full", 32'(a_full), 0);
    chk("rst_cursor", 32'({a_row, a_col}), 0);
    chk("rst_base", 32'(a_base), 0);
    chk("rst_busy", 32'(a_busy), 1);
    chk("rst_ready", 32'(a_ready), 0);
    rst = 1'b0;

    // Power-up clear: 32 fills in row-major order.
    for (int i = 0; i < 32; i++) begin
      tick();
      chk_wr($sformatf("pwr_clr%0d", i), 5'(i), 8'h20, 1);
    end
    chk("pwr_ready", 32'(a_ready), 1);
    chk("pwr_busy", 32'(a_busy), 0);
    chk("pwr_cursor", 32'({a_row, a_col}), 0);

    // Back-to-back printable bytes.
    valid = 1'b1; data = 8'h41; tick();
    chk_wr("chA", 5'd0, 8'h41, 1);
    chk("chA_col", 32'(a_col), 1);
    data = 8'h42; tick();
    chk_wr("chB", 5'd1, 8'h42, 1);
    chk("chB_col", 32'(a_col), 2);
    data = 8'h43; tick();
    chk_wr("chC", 5'd2, 8'h43, 0);
    valid = 1'b0;

    // Backspace from col 3, CR, then backspace at col 0 (no-op).
    send(8'h08);
    chk_wr("bs1", 5'd2, 8'h20, 0);
    chk("bs1_col", 32'(a_col), 2);
    send(8'h0D);
    chk("cr_we", 32'(a_we), 0);
    chk("cr_col", 32'(a_col), 0);
    send(8'h08);
    chk("bs0_we", 32'(a_we), 0);
    chk("bs0_col", 32'(a_col), 0);

    // Eight 'x' fill the line; the last one wraps and clears row 1.
    valid = 1'b1; data = 8'h78;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_wr($sformatf("x%0d", i), 5'(i), 8'h78, 0);
    end
    chk("wrap_ready", 32'(a_ready), 0);
    chk("wrap_cursor", 32'({a_row, a_col}), 32'({2'd1, 3'd0}));
    valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("wrap_busy_rdy%0d", i), 32'(a_ready), 0);
      tick();
      chk_wr($sformatf("wrap_clr%0d", i), 5'(8 + i), 8'h20, 1);
    end
    chk("wrap_ready_after", 32'(a_ready), 1);

    // LF to rows 2 and 3, each clearing its line.
    for (int r = 2; r < 4; r++) begin
      send(8'h0A);
      chk($sformatf("lf%0d_we", r), 32'(a_we), 0);
      chk($sformatf("lf%0d_row", r), 32'(a_row), 32'(r));
      for (int i = 0; i < 8; i++) begin
        tick();
        chk_wr($sformatf("lf%0d_clr%0d", r, i), 5'(r * 8 + i), 8'h20, 0);
      end
    end

    // LF at the bottom line: A scrolls, B wraps with an o_full pulse.
    send(8'h0A);
    chk("scr_row", 32'(a_row), 3);
    chk("scr_base", 32'(a_base), 1);
    chk("scr_full_a", 32'(a_full), 0);
    chk("wrp_cursor", 32'({b_row, b_col}), 0);
    chk("wrp_base", 32'(b_base), 0);
    chk("wrp_full", 32'(b_full), 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) chk("wrp_full_drop", 32'(b_full), 0);
      chk_wr($sformatf("scr_clr%0d", i), 5'(i), 8'h20, 1);
    end

    // Cursor row 3 + base 1 maps to physical row 0.
    send(8'h5A);
    chk_wr("scrZ", 5'd0, 8'h5A, 1);
    chk("scrZ_cursor", 32'({a_row, a_col}), 32'({2'd3, 3'd1}));

    // Second scroll: base 1 -> 2, clears physical row 1.
    send(8'h0A);
    chk("scr2_base", 32'(a_base), 2);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_wr($sformatf("scr2_clr%0d", i), 5'(8 + i), 8'h20, 1);
    end
    // Row 3 + base 2 = 5 -> physical row 1.
    send(8'h4B);
    chk_wr("scrK", 5'd8, 8'h4B, 1);

    // i_clear with i_valid: byte refused, clear starts.
    clr = 1'b1; valid = 1'b1; data = 8'h51;
    #1;
    chk("clr_ready", 32'(a_ready), 0);
    tick();
    clr = 1'b0; valid = 1'b0;
    chk("clr_we", 32'(a_we), 0);
    chk("clr_busy", 32'(a_busy), 1);
    chk("clr_col_hold", 32'(a_col), 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_wr($sformatf("clr1_%0d", i), 5'(i), 8'h20, 0);
    end
    // Re-assert mid-clear: restart from cell 0.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr2_we", 32'(a_we), 0);
    for (int i = 0; i < 32; i++) begin
      tick();
      chk_wr($sformatf("clr2_%0d", i), 5'(i), 8'h20, 1);
    end
    chk("clr_done_ready", 32'(a_ready), 1);
    chk("clr_done_cursor", 32'({a_row, a_col}), 0);
    chk("clr_done_base", 32'(a_base), 0);
    chk("clr_done_b_cursor", 32'({b_row, b_col}), 0);
    tick();
    chk("idle_we", 32'(a_we), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
